adpcmb_play_ctrl: RTL and testbench
===================================

Name: adpcmb_play_ctrl

Overview:
- Playback sequencer for the single-channel ADPCM-B decoder.
- Fetches sample bytes from sample ROM over a req/ack handshake and double-buffers them.
- Splits each byte into nibbles and generates the decoder's adv, clr and chon controls.
- Drives adv from a delta-N phase accumulator (sample rate = f_cen * delta_n / 2^16); handles start, stop, repeat and end-of-sample.

Parameters:
AW, 24, byte address width of sample ROM
ACCW, 16, phase accumulator / delta_n width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; accumulator and adv only advance on cen
start  in  1  one-clk pulse: begin playback from start_pg
stop  in  1  one-clk pulse: abort playback
rpt  in  1  loop at end instead of stopping (sampled continuously)
start_pg  in  AW-8  start page; first byte = {start_pg,8'h00}
end_pg  in  AW-8  end page; last byte = {end_pg,8'hFF}
delta_n  in  ACCW  phase increment per cen
flag_clr  in  1  clears eos flag
rom_req  out  1  fetch request
rom_addr  out  AW  fetch byte address, stable while rom_req high
rom_ack  in  1  one-clk pulse, rom_data valid same clk
rom_data  in  8  fetched byte
data  out  4  nibble to decoder
adv  out  1  one-clk decoder advance strobe, asserted only on a cen clk
clr  out  1  one-clk decoder clear
chon  out  1  decoder channel enable
busy  out  1  state != IDLE
eos  out  1  sticky end-of-sample flag
underrun  out  1  sticky: rate tick with no data available

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0. Accumulator 0. Both buffers invalid. fetch_addr = 0. play_addr = 0. nib = 0.
- States:
  - IDLE: chon=0, rom_req=0.
  - LOAD: wait for first byte.
  - PLAY: chon=1.
- start (any state): fetch_addr <= {start_pg,0}; acc <= 0; buffers invalidated; nib <= 0; eos <= 0; underrun <= 0; clr=1 for that clk; state -> LOAD.
- stop (any state): state -> IDLE; rom_req drops next clk. stop wins over a simultaneous start.
- Fetch engine, active in LOAD/PLAY:
  - Request condition: nxt buffer empty, and fetch not exhausted. Exhausted = fetch_addr passed {end_pg,FF} with rpt=0.
  - Request: rom_req=1, rom_addr=fetch_addr, both held until rom_ack.
  - On rom_ack: nxt <= rom_data; nxt valid; fetch_addr+1.
  - Wrap: if the acked address == {end_pg,FF} and rpt=1, fetch_addr <= {start_pg,0} instead.
  - rom_ack while rom_req=0 is ignored.
- Buffer move: when cur is invalid and nxt is valid, cur <= nxt and play_addr <= address of that byte. One clk; must not overlap an adv clk.
- LOAD -> PLAY when cur becomes valid.
- data = nib ? cur[3:0] : cur[7:4]. High nibble plays first. data = 0 when cur is invalid.
- Accumulator (PLAY only, on cen): {carry,acc} <= acc + delta_n.
  - carry with cur valid: adv=1 that clk, then nib toggles. When nib goes 1->0, cur is invalidated (consumed).
  - carry with cur invalid: no adv; underrun <= 1; tick lost.
  - delta_n = 0: never advances. delta_n = 2^ACCW-1: carry on almost every cen.
- End handling on consumption of the low nibble of play_addr == {end_pg,FF}:
  - rpt=1: clr=1 for one clk on the clk after that adv; playback continues from the start byte already prefetched; eos unchanged.
  - rpt=0: eos <= 1; state -> IDLE, so chon falls on the next clk.
- eos: set at end, cleared by flag_clr or start. flag_clr and set in the same clk: set wins.
- start_pg > end_pg: treated as 2^(AW-8)-page wrap; fetch continues until the address equals the end byte. No special case.

Test Plan:
1. Reset mid-PLAY with rom_req high -> rom_req=0, chon=0, eos=0, busy=0 within the reset clk (asynchronous).
2. start_pg=0x0001, end_pg=0x0001, delta_n=0x8000, cen=1 every clk, ROM byte 0x100=0xA7 -> rom_addr 0x000100 first; data 0xA at the first adv, 0x7 at the second; adv every 2 clks.
3. Same setup, rpt=0 -> after 512 adv pulses eos=1, chon=0, busy=0; no further rom_req.
4. Same setup, rpt=1 -> after adv #512: one clr pulse, the next fetch is 0x000100 again, eos stays 0, adv cadence unbroken.
5. rom_ack delayed 40 clks per byte, delta_n=0xFFFF -> underrun=1, no adv while cur invalid, rom_addr held stable during each wait.
6. start and stop in the same clk while PLAY -> state IDLE, no clr pulse; later lone start -> clr pulse, LOAD, first fetch {start_pg,00}.

Source files
------------

// File: rtl/adpcmb_play_ctrl_if.sv
// Sample-ROM fetch bus between the ADPCM-B playback sequencer and its ROM arbiter.
// The master drives req/addr and the slave answers with a single-clk ack plus the data byte.
interface adpcmb_play_ctrl_if #(
  parameter int unsigned AW = 24
) ();
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic          rom_ack;
  logic [7:0]    rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );
endinterface

// File: rtl/adpcmb_play_ctrl.sv
// ADPCM-B playback sequencer: double-buffered ROM byte fetch, nibble split and
// delta-N phase accumulator that paces the decoder's adv strobe.
module adpcmb_play_ctrl #(
  parameter int unsigned AW   = 24,
  parameter int unsigned ACCW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                start,
  input  logic                stop,
  input  logic                rpt,
  input  logic [AW-9:0]       start_pg,
  input  logic [AW-9:0]       end_pg,
  input  logic [ACCW-1:0]     delta_n,
  input  logic                flag_clr,
  adpcmb_play_ctrl_if.master  rom,
  output logic [3:0]          data,
  output logic                adv,
  output logic                clr,
  output logic                chon,
  output logic                busy,
  output logic                eos,
  output logic                underrun
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StPlay = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [7:0]      nxt_q, nxt_d;
  logic            nxt_vld_q, nxt_vld_d;
  logic [AW-1:0]   nxt_addr_q, nxt_addr_d;
  logic [7:0]      cur_q, cur_d;
  logic            cur_vld_q, cur_vld_d;
  logic [AW-1:0]   play_addr_q, play_addr_d;
  logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
  logic            exh_q, exh_d;
  logic            nib_q, nib_d;
  logic            eos_q, eos_d;
  logic            underrun_q, underrun_d;
  logic            rclr_q, rclr_d;

  logic [AW-1:0]   start_addr, end_addr;
  logic            do_start, active, fetch_ok, move, play_en;
  logic            carry, tick, consume, at_end;
  logic [ACCW-1:0] acc_sum;

  assign start_addr = {start_pg, 8'h00};
  assign end_addr   = {end_pg, 8'hFF};

  // stop beats a simultaneous start
  assign do_start = start & ~stop;
  assign active   = (state_q != StIdle);

  assign rom.rom_req  = active & ~nxt_vld_q & ~exh_q;
  assign rom.rom_addr = fetch_addr_q;

  assign fetch_ok = rom.rom_req & rom.rom_ack & ~do_start;
  assign move     = active & ~cur_vld_q & nxt_vld_q;

  // No rate ticks on a start/stop clk so a restart or abort never emits a stray adv.
  assign play_en            = (state_q == StPlay) & cen & ~start & ~stop;
  assign {carry, acc_sum}   = {1'b0, acc_q} + {1'b0, delta_n};
  assign tick               = play_en & carry;
  assign adv                = tick & cur_vld_q;
  assign consume            = adv & nib_q;
  assign at_end             = consume & (play_addr_q == end_addr);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    nxt_d        = nxt_q;
    nxt_vld_d    = nxt_vld_q;
    nxt_addr_d   = nxt_addr_q;
    cur_d        = cur_q;
    cur_vld_d    = cur_vld_q;
    play_addr_d  = play_addr_q;
    fetch_addr_d = fetch_addr_q;
    exh_d        = exh_q;
    nib_d        = nib_q;
    eos_d        = eos_q;
    underrun_d   = underrun_q;
    rclr_d       = 1'b0;

    if (play_en) begin
      acc_d = acc_sum;
    end

    if (fetch_ok) begin
      nxt_d      = rom.rom_data;
      nxt_vld_d  = 1'b1;
      nxt_addr_d = fetch_addr_q;
      if (fetch_addr_q == end_addr && rpt) begin
        fetch_addr_d = start_addr;
      end else begin
        fetch_addr_d = fetch_addr_q + AW'(1);
        if (fetch_addr_q == end_addr) begin
          exh_d = 1'b1;
        end
      end
    end

    // move needs cur empty and adv needs cur full, so the two never share a clk
    if (move) begin
      cur_d       = nxt_q;
      cur_vld_d   = 1'b1;
      play_addr_d = nxt_addr_q;
      nxt_vld_d   = 1'b0;
      if (state_q == StLoad) begin
        state_d = StPlay;
      end
    end

    if (adv) begin
      nib_d = ~nib_q;
      if (nib_q) begin
        cur_vld_d = 1'b0;
      end
    end

    if (tick && !cur_vld_q) begin
      underrun_d = 1'b1;
    end

    if (at_end) begin
      if (rpt) begin
        rclr_d = 1'b1;
      end else begin
        eos_d   = 1'b1;
        state_d = StIdle;
      end
    end else if (flag_clr) begin
      eos_d = 1'b0;
    end

    if (do_start) begin
      state_d      = StLoad;
      fetch_addr_d = start_addr;
      acc_d        = '0;
      nxt_vld_d    = 1'b0;
      cur_vld_d    = 1'b0;
      nib_d        = 1'b0;
      eos_d        = 1'b0;
      underrun_d   = 1'b0;
      exh_d        = 1'b0;
      rclr_d       = 1'b0;
    end

    if (stop) begin
      state_d = StIdle;
      rclr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      nxt_q        <= '0;
      nxt_vld_q    <= 1'b0;
      nxt_addr_q   <= '0;
      cur_q        <= '0;
      cur_vld_q    <= 1'b0;
      play_addr_q  <= '0;
      fetch_addr_q <= '0;
      exh_q        <= 1'b0;
      nib_q        <= 1'b0;
      eos_q        <= 1'b0;
      underrun_q   <= 1'b0;
      rclr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      nxt_q        <= nxt_d;
      nxt_vld_q    <= nxt_vld_d;
      nxt_addr_q   <= nxt_addr_d;
      cur_q        <= cur_d;
      cur_vld_q    <= cur_vld_d;
      play_addr_q  <= play_addr_d;
      fetch_addr_q <= fetch_addr_d;
      exh_q        <= exh_d;
      nib_q        <= nib_d;
      eos_q        <= eos_d;
      underrun_q   <= underrun_d;
      rclr_q       <= rclr_d;
    end
  end

  assign data     = cur_vld_q ? (nib_q ? cur_q[3:0] : cur_q[7:4]) : 4'h0;
  assign clr      = do_start | rclr_q;
  assign chon     = (state_q == StPlay);
  assign busy     = active;
  assign eos      = eos_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_adpcmb_play_ctrl.sv
// Bench for adpcmb_play_ctrl: ROM responder, nibble-stream / phase model checked
// every clk, plus literal expectations for the directed scenarios.
module tb_adpcmb_play_ctrl;
  localparam int unsigned AW   = 24;
  localparam int unsigned ACCW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cen = 1'b0, start = 1'b0, stop = 1'b0, rpt = 1'b0, flag_clr = 1'b0;
  logic [AW-9:0]   start_pg = '0, end_pg = '0;
  logic [ACCW-1:0] delta_n = '0;
  logic [3:0]      data;
  logic            adv, clr, chon, busy, eos, underrun;

  adpcmb_play_ctrl_if #(.AW(AW)) bus ();

  adpcmb_play_ctrl #(.AW(AW), .ACCW(ACCW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .start    (start),
    .stop     (stop),
    .rpt      (rpt),
    .start_pg (start_pg),
    .end_pg   (end_pg),
    .delta_n  (delta_n),
    .flag_clr (flag_clr),
    .rom      (bus),
    .data     (data),
    .adv      (adv),
    .clr      (clr),
    .chon     (chon),
    .busy     (busy),
    .eos      (eos),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] rom_mem [0:4095];
  int rom_lat = 0;
  int wait_cnt = 0;
  int cyc = 0;
  bit strict = 1'b1;

  // model of the expected playback
  logic [ACCW-1:0] m_acc;
  logic [AW-1:0]   m_fetch, m_byte;
  bit m_nib, m_exh, m_eos, m_unr, m_rclr, m_end;
  bit p_req, p_ack, p_skip, p_fetch_end;
  logic [AW-1:0] p_addr;

  // observations used by the literal checks
  int dut_adv, ack_cnt, clr_cnt, last_adv_cyc, min_gap, max_gap;
  logic [3:0] adv_data0, adv_data1;
  logic [AW-1:0] first_fetch, after_end_addr;
  bit got_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic restart_model();
    m_acc = '0; m_fetch = {start_pg, 8'h00}; m_byte = {start_pg, 8'h00};
    m_nib = 0; m_exh = 0; m_eos = 0; m_unr = 0; m_rclr = 0; m_end = 0;
    dut_adv = 0; ack_cnt = 0; clr_cnt = 0; last_adv_cyc = -1; min_gap = 1 << 30; max_gap = 0;
    got_first = 0; p_fetch_end = 0; after_end_addr = '1;
  endtask

  task automatic compare();
    bit s, tk, set_now, exp_clr;
    logic [ACCW:0] sum;
    logic [7:0] b;
    logic [3:0] exp_nib;
    logic [AW-1:0] sa, ea;
    sa = {start_pg, 8'h00};
    ea = {end_pg, 8'hFF};
    s = start && !stop;
    cyc++;
    if (clr) clr_cnt++;
    chk("eos", eos, m_eos);
    chk("underrun", underrun, m_unr);
    exp_clr = s || m_rclr;
    chk("clr", clr, exp_clr);
    if (m_end) begin
      chk("chon_after_end", chon, 0);
      chk("busy_after_end", busy, 0);
    end
    if (m_exh) chk("no_fetch_after_end", bus.rom_req, 0);
    if (p_req && !p_ack && !p_skip) begin
      chk("req_held", bus.rom_req, 1);
      chk("addr_held", bus.rom_addr, p_addr);
    end
    if (adv) chk("adv_on_cen", cen, 1);
    m_rclr = 0;
    m_end = 0;

    if (bus.rom_req && bus.rom_ack && !s) begin
      ack_cnt++;
      chk("fetch_addr", bus.rom_addr, m_fetch);
      if (!got_first) begin first_fetch = bus.rom_addr; got_first = 1; end
      if (p_fetch_end) after_end_addr = bus.rom_addr;
      p_fetch_end = (m_fetch == ea);
      if (m_fetch == ea && rpt) m_fetch = sa;
      else begin
        if (m_fetch == ea) m_exh = 1;
        m_fetch = m_fetch + 1'b1;
      end
    end

    // rate ticks: carries of acc + delta_n over the cen clks spent playing
    tk = 0;
    if (chon && cen && !start && !stop) begin
      sum = {1'b0, m_acc} + {1'b0, delta_n};
      m_acc = sum[ACCW-1:0];
      tk = sum[ACCW];
    end
    if (strict) chk("adv", adv, tk);
    else if (adv) chk("adv_needs_tick", tk, 1);
    if (tk && !adv) m_unr = 1;

    set_now = 0;
    if (adv) begin
      dut_adv++;
      if (dut_adv == 1) adv_data0 = data;
      if (dut_adv == 2) adv_data1 = data;
      if (last_adv_cyc >= 0) begin
        if (cyc - last_adv_cyc < min_gap) min_gap = cyc - last_adv_cyc;
        if (cyc - last_adv_cyc > max_gap) max_gap = cyc - last_adv_cyc;
      end
      last_adv_cyc = cyc;
      b = rom_mem[m_byte[11:0]];
      exp_nib = m_nib ? b[3:0] : b[7:4];
      chk("data", data, exp_nib);
      chk("adv_after_fetch", dut_adv <= 2 * ack_cnt, 1);
      if (m_nib) begin
        if (m_byte == ea) begin
          if (rpt) begin m_rclr = 1; m_byte = sa; end
          else begin m_eos = 1; m_end = 1; set_now = 1; end
        end else m_byte = m_byte + 1'b1;
      end
      m_nib = !m_nib;
    end
    if (flag_clr && !set_now) m_eos = 0;
    if (s) restart_model();
    p_req = bus.rom_req; p_ack = bus.rom_ack; p_addr = bus.rom_addr; p_skip = start || stop;
  endtask

  task automatic step();
    if (bus.rom_ack) bus.rom_ack = 1'b0;
    else if (bus.rom_req) begin
      if (wait_cnt >= rom_lat) begin
        bus.rom_ack = 1'b1;
        bus.rom_data = rom_mem[bus.rom_addr[11:0]];
        wait_cnt = 0;
      end else wait_cnt++;
    end
    @(negedge clk);
    if (rst_n) compare();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic reset_hold();
    rst_n = 1'b0; start = 0; stop = 0; flag_clr = 0;
    bus.rom_ack = 1'b0; wait_cnt = 0;
    restart_model();
    p_req = 0; p_ack = 0; p_skip = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rom_ack = 1'b0;
    bus.rom_data = 8'h00;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i * 37 + 11);
    rom_mem[12'h100] = 8'hA7;

    // reset state
    reset_hold();
    chk("rst_req", bus.rom_req, 0);
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_chon", chon, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adv_clr", {adv, clr, eos, underrun}, 0);
    chk("rst_data", data, 0);
    rst_n = 1'b1;
    step();

    // single page, one adv every 2 clks, no repeat
    start_pg = 16'h0001; end_pg = 16'h0001; delta_n = 16'h8000; cen = 1; rpt = 0;
    rom_lat = 0; strict = 1;
    pulse_start();
    for (int i = 0; i < 50 && dut_adv < 3; i++) step();
    chk("first_fetch", first_fetch, 24'h000100);
    chk("first_adv_data", adv_data0, 4'hA);
    chk("second_adv_data", adv_data1, 4'h7);
    for (int i = 0; i < 3000 && !eos; i++) step();
    chk("adv_count_at_eos", dut_adv, 512);
    chk("eos_set", eos, 1);
    chk("chon_off", chon, 0);
    chk("busy_off", busy, 0);
    chk("cadence_min", min_gap, 2);
    chk("cadence_max", max_gap, 2);
    repeat (20) step();
    chk("idle_no_req", bus.rom_req, 0);
    flag_clr = 1; step(); flag_clr = 0;
    chk("eos_cleared", eos, 0);

    // repeat: one clr after the last nibble, refetch from the start byte
    rpt = 1;
    pulse_start();
    for (int i = 0; i < 3000 && dut_adv < 520; i++) step();
    chk("rpt_adv_reached", dut_adv >= 520, 1);
    chk("rpt_clr_count", clr_cnt, 1);
    chk("rpt_refetch", after_end_addr, 24'h000100);
    chk("rpt_eos", eos, 0);
    chk("rpt_cadence_min", min_gap, 2);
    chk("rpt_cadence_max", max_gap, 2);
    chk("rpt_no_underrun", underrun, 0);

    // start + stop together while playing, then a lone start
    start = 1; stop = 1;
    #1 chk("clr_on_start_stop", clr, 0);
    step();
    start = 0; stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_chon", chon, 0);
    repeat (5) step();
    start_pg = 16'h0002; end_pg = 16'h0002;
    start = 1;
    #1 chk("clr_on_start", clr, 1);
    step();
    start = 0;
    chk("load_busy", busy, 1);
    chk("load_chon", chon, 0);
    chk("load_req", bus.rom_req, 1);
    chk("load_addr", bus.rom_addr, 24'h000200);
    repeat (10) step();

    // slow ROM with near-maximal rate: ticks are lost
    rpt = 0; rom_lat = 40; delta_n = 16'hFFFF; strict = 0;
    pulse_start();
    repeat (300) step();
    chk("underrun_set", underrun, 1);
    chk("some_adv", dut_adv > 0, 1);

    // asynchronous reset in the middle of a pending fetch
    for (int i = 0; i < 100 && !(bus.rom_req && chon); i++) step();
    chk("pre_reset_req", bus.rom_req && chon, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", bus.rom_req, 0);
    chk("async_chon", chon, 0);
    chk("async_busy", busy, 0);
    chk("async_flags", {eos, underrun, adv}, 0);
    reset_hold();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
